// File: rtl/lemming_arena.sv
`timescale 1ns/1ps
// Lemming walker arena: moves pos_x one cell per prescaled tick and emits registered bump pulses at walls.
// The optional obstacle cell is enabled with ARENA_OBSTACLE_EN; pos/bump/count update one cycle after the tick.
module lemming_arena #(
  parameter int XW       = 6,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 39,
  parameter int X_START  = 20,
  parameter int STEP_DIV = 4
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          walk_left,
  input  logic          walk_right,
  input  logic          pause,
`ifdef ARENA_OBSTACLE_EN
  input  logic          obstacle_valid,
  input  logic [XW-1:0] obstacle_x,
`endif
  output logic [XW-1:0] pos_x,
  output logic          bump_left,
  output logic          bump_right,
  output logic          step_tick,
  output logic [7:0]    bounce_count
);

  localparam int              PW      = $clog2(STEP_DIV);
  localparam logic [PW-1:0]   L_LAST  = PW'(STEP_DIV - 1);
  localparam logic [XW-1:0]   L_MIN   = XW'(X_MIN);
  localparam logic [XW-1:0]   L_MAX   = XW'(X_MAX);
  localparam logic [XW-1:0]   L_START = XW'(X_START);

  logic [PW-1:0] r_presc;
  logic [XW-1:0] r_pos;
  logic          r_bump_left;
  logic          r_bump_right;
  logic [7:0]    r_count;

  logic          w_tick;
  logic          w_go_left;
  logic          w_go_right;
  logic [XW-1:0] w_pos_dec;
  logic [XW-1:0] w_pos_inc;
  logic          w_blk_left;
  logic          w_blk_right;
  logic          w_obs_left;
  logic          w_obs_right;
  logic [XW-1:0] w_pos_nxt;
  logic          w_bl_nxt;
  logic          w_br_nxt;

  assign w_tick     = (r_presc == L_LAST) && !pause;
  assign w_go_left  = walk_left && !walk_right;
  assign w_go_right = walk_right && !walk_left;
  assign w_pos_dec  = r_pos - XW'(1);
  assign w_pos_inc  = r_pos + XW'(1);

`ifdef ARENA_OBSTACLE_EN
  // An occupied target cell behaves exactly like a wall on the side of travel.
  assign w_obs_left  = obstacle_valid && (obstacle_x == w_pos_dec);
  assign w_obs_right = obstacle_valid && (obstacle_x == w_pos_inc);
`else
  assign w_obs_left  = 1'b0;
  assign w_obs_right = 1'b0;
`endif

  assign w_blk_left  = (r_pos == L_MIN) || w_obs_left;
  assign w_blk_right = (r_pos == L_MAX) || w_obs_right;

  always_comb begin
    w_pos_nxt = r_pos;
    w_bl_nxt  = 1'b0;
    w_br_nxt  = 1'b0;
    if (w_tick) begin
      if (w_go_left) begin
        if (w_blk_left) w_bl_nxt = 1'b1;
        else            w_pos_nxt = w_pos_dec;
      end else if (w_go_right) begin
        if (w_blk_right) w_br_nxt = 1'b1;
        else             w_pos_nxt = w_pos_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_presc      <= '0;
      r_pos        <= L_START;
      r_bump_left  <= 1'b0;
      r_bump_right <= 1'b0;
      r_count      <= 8'd0;
    end else begin
      if (!pause) r_presc <= (r_presc == L_LAST) ? '0 : r_presc + PW'(1);
      r_pos        <= w_pos_nxt;
      r_bump_left  <= w_bl_nxt;
      r_bump_right <= w_br_nxt;
      if ((w_bl_nxt || w_br_nxt) && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

  assign pos_x        = r_pos;
  assign bump_left    = r_bump_left;
  assign bump_right   = r_bump_right;
  assign step_tick    = w_tick;
  assign bounce_count = r_count;

endmodule

// File: tb/tb_lemming_arena.sv
`timescale 1ns/1ps
// Directed bench for lemming_arena: tick table plus reset, pause, closed-loop and saturation sequences.
module tb_lemming_arena;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       walk_left = 1'b0;
  logic       walk_right = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] pos_x;
  logic       bump_left;
  logic       bump_right;
  logic       step_tick;
  logic [7:0] bounce_count;
`ifdef ARENA_OBSTACLE_EN
  logic       obstacle_valid = 1'b0;
  logic [5:0] obstacle_x = 6'd0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lemming_arena dut (
    .clk          (clk),
    .areset       (areset),
    .walk_left    (walk_left),
    .walk_right   (walk_right),
    .pause        (pause),
`ifdef ARENA_OBSTACLE_EN
    .obstacle_valid (obstacle_valid),
    .obstacle_x     (obstacle_x),
`endif
    .pos_x        (pos_x),
    .bump_left    (bump_left),
    .bump_right   (bump_right),
    .step_tick    (step_tick),
    .bounce_count (bounce_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait (at negedges) for a tick, then step to the cycle where its effect is visible.
  task automatic run_tick(input logic wl, input logic wr);
    bit found;
    walk_left  = wl;
    walk_right = wr;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (step_tick) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) chk("tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  // After release, step_tick must be low for prescaler 0..2 and high at 3.
  task automatic chk_first_tick(input string name);
    for (int k = 0; k < 4; k++) begin
      chk(name, int'(step_tick), (k == 3) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic wl;
    logic wr;
    int   reps;
    int   pos;
    int   bl;
    int   br;
    int   cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int nl, nr, dbl, last_wall, cyc;
    bit dir_left, done;

    tbl[0]  = '{1'b1, 1'b0, 1,  19, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1,  20, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 10, 20, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1,  20, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 18, 2,  0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1,  1,  0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1,  0,  0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1,  0,  1, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1,  0,  1, 0, 2};
    tbl[9]  = '{1'b0, 1'b1, 1,  1,  0, 0, 2};
    tbl[10] = '{1'b0, 1'b1, 38, 39, 0, 0, 2};
    tbl[11] = '{1'b0, 1'b1, 1,  39, 0, 1, 3};
    tbl[12] = '{1'b1, 1'b0, 1,  38, 0, 0, 3};

    // Reset state, then first-tick timing after release.
    #12;
    chk("rst_pos", int'(pos_x), 20);
    chk("rst_cnt", int'(bounce_count), 0);
    chk("rst_bumps", int'({bump_left, bump_right}), 0);
    chk("rst_tick", int'(step_tick), 0);
    @(negedge clk);
    areset = 1'b0;
    chk_first_tick("first_tick");

    foreach (tbl[v]) begin
      for (int r = 0; r < tbl[v].reps; r++) run_tick(tbl[v].wl, tbl[v].wr);
      chk($sformatf("vec%0d_pos", v), int'(pos_x), tbl[v].pos);
      chk($sformatf("vec%0d_bl", v), int'(bump_left), tbl[v].bl);
      chk($sformatf("vec%0d_br", v), int'(bump_right), tbl[v].br);
      chk($sformatf("vec%0d_cnt", v), int'(bounce_count), tbl[v].cnt);
      @(negedge clk);
      chk($sformatf("vec%0d_bump_fall", v), int'({bump_left, bump_right}), 0);
      chk($sformatf("vec%0d_pos_hold", v), int'(pos_x), tbl[v].pos);
    end
    walk_left  = 1'b0;
    walk_right = 1'b0;

    // Asynchronous reset between clock edges, mid-period.
    @(negedge clk);
    @(negedge clk);
    #2 areset = 1'b1;
    #1;
    chk("async_pos", int'(pos_x), 20);
    chk("async_cnt", int'(bounce_count), 0);
    chk("async_tick", int'(step_tick), 0);
    @(negedge clk);
    areset = 1'b0;
    chk_first_tick("mid_rst_tick");

    // Pause for 7 cycles mid-period stretches tick spacing from 4 to 11.
    cyc = 0;
    done = 1'b0;
    for (int i = 0; i < 12 && !step_tick; i++) @(negedge clk);
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (step_tick) begin
        cyc = c;
        done = 1'b1;
      end
      if (c == 2) pause = 1'b1;
      if (c == 9) pause = 1'b0;
    end
    pause = 1'b0;
    chk("pause_spacing", cyc, 11);
    chk("pause_pos", int'(pos_x), 20);

    // Closed loop walker that turns on every bump, starting leftward.
    dir_left = 1'b1;
    nl = 0; nr = 0; dbl = 0; last_wall = 0;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (bump_left) begin
        nl++;
        if (last_wall == 1) dbl++;
        last_wall = 1;
        dir_left = 1'b0;
      end
      if (bump_right) begin
        nr++;
        if (last_wall == 2) dbl++;
        last_wall = 2;
        dir_left = 1'b1;
        done = 1'b1;
      end
      walk_left  = dir_left;
      walk_right = !dir_left;
      @(negedge clk);
    end
    walk_left  = 1'b0;
    walk_right = 1'b0;
    chk("loop_done", int'(done), 1);
    chk("loop_left_bumps", nl, 1);
    chk("loop_right_bumps", nr, 1);
    chk("loop_double_bumps", dbl, 0);
    chk("loop_cnt", int'(bounce_count), 2);
    chk("loop_pos", int'(pos_x), 39);

    // bounce_count saturates at 255.
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    walk_left = 1'b1;
    for (int c = 0; c < 1600 && bounce_count != 8'd255; c++) @(negedge clk);
    chk("sat_reach", int'(bounce_count), 255);
    for (int t = 0; t < 5; t++) run_tick(1'b1, 1'b0);
    chk("sat_hold_cnt", int'(bounce_count), 255);
    chk("sat_bump", int'(bump_left), 1);
    chk("sat_pos", int'(pos_x), 0);
    walk_left = 1'b0;

`ifdef ARENA_OBSTACLE_EN
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    for (int t = 0; t < 4; t++) run_tick(1'b0, 1'b1);
    chk("obs_pre_pos", int'(pos_x), 24);
    obstacle_x     = 6'd25;
    obstacle_valid = 1'b1;
    run_tick(1'b0, 1'b1);
    chk("obs_pos", int'(pos_x), 24);
    chk("obs_br", int'(bump_right), 1);
    chk("obs_bl", int'(bump_left), 0);
    chk("obs_cnt", int'(bounce_count), 1);
    obstacle_valid = 1'b0;
    walk_right = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
